// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the pipeline hazard controller.
//   - opcode constants for the instruction classes the controller cares about
//   - bit positions of the opcode / register fields in a 32-bit instruction
//   - controller FSM state type
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b010100;
  localparam logic [5:0] OP_SW    = 6'b010101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001101;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/hazard_decode.sv
// hazard_decode: purely combinational classifier for the instruction in ID.
// Ports:
//   ins      in  32  instruction word
//   reads_rs out 1   instruction sources register rs
//   reads_rt out 1   instruction sources register rt
//   dst      out 5   destination register (0 = no destination)
//   is_load  out 1   instruction is a load
//   is_mem   out 1   instruction accesses data memory
module hazard_decode
  import mips_pkg::*;
(
  input  logic [31:0] ins,
  output logic        reads_rs,
  output logic        reads_rt,
  output logic [4:0]  dst,
  output logic        is_load,
  output logic        is_mem
);

  logic [5:0] op;
  logic       unused_low;

  assign op = ins[OP_HI:OP_LO];
  // Immediate / shamt / funct bits never influence hazards.
  assign unused_low = ^ins[RD_LO-1:0];

  always_comb begin
    // Unknown opcodes are treated conservatively as reading rs only.
    reads_rs = 1'b1;
    reads_rt = 1'b0;
    dst      = 5'd0;
    is_load  = 1'b0;
    is_mem   = 1'b0;
    case (op)
      OP_RTYPE: begin
        reads_rt = 1'b1;
        dst      = ins[RD_HI:RD_LO];
      end
      OP_LW: begin
        dst     = ins[RT_HI:RT_LO];
        is_load = 1'b1;
        is_mem  = 1'b1;
      end
      OP_SW: begin
        reads_rt = 1'b1;
        is_mem   = 1'b1;
      end
      OP_BEQ: begin
        reads_rt = 1'b1;
      end
      OP_ADDI: begin
        dst = ins[RT_HI:RT_LO];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage core.
// Drives stage-register enables/flushes: one-cycle bubble on load-use,
// wrong-path flush on taken branch, and a full-pipeline freeze while data
// memory completes an access (req/ack with timeout).
// Ports:
//   clk, reset (sync, active-high)
//   ins, ins_valid       instruction in ID
//   br_taken             branch in EX resolved taken
//   mem_ack              data memory completes current access
//   pc_en/ifid_en/idex_en/exmem_en   stage-register load enables
//   ifid_flush/idex_flush            load a bubble into that register
//   mem_req              access request for the instruction in MEM
//   mem_err              sticky memory timeout flag
//   stall_cycles         saturating count of cycles with pc_en=0
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ins,
  input  logic             ins_valid,
  input  logic             br_taken,
  input  logic             mem_ack,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             mem_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  logic       reads_rs, reads_rt, is_load, is_mem;
  logic [4:0] dst;

  hazard_decode u_decode (
    .ins      (ins),
    .reads_rs (reads_rs),
    .reads_rt (reads_rt),
    .dst      (dst),
    .is_load  (is_load),
    .is_mem   (is_mem)
  );

  // Shadow copies of what sits in EX and MEM.
  logic              ex_vld_q, ex_ld_q, ex_mem_q;
  logic [4:0]        ex_dst_q;
  logic              mem_vld_q, mem_mem_q;
  state_e            state_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic              mem_err_q;
  logic [CNT_W-1:0]  stall_q;

  logic timeout_hit, freeze, load_use, rs_hit, rt_hit;

  always_comb begin
    mem_req     = mem_vld_q & mem_mem_q & ~reset;
    timeout_hit = (state_q == MEM_WAIT) && (wait_cnt_q == WAIT_LAST);
    // A timeout acts as a forced ack, releasing the freeze that same cycle.
    freeze      = mem_req & ~mem_ack & ~timeout_hit;
    rs_hit      = reads_rs && (ins[RS_HI:RS_LO] == ex_dst_q);
    rt_hit      = reads_rt && (ins[RT_HI:RT_LO] == ex_dst_q);
    load_use    = ins_valid & ex_vld_q & ex_ld_q & (ex_dst_q != 5'd0) & (rs_hit | rt_hit);

    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (reset) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (freeze) begin
      // Frozen: EX is held, so a pending taken branch is flushed on release.
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
    end else if (br_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_vld_q   <= 1'b0;
      ex_ld_q    <= 1'b0;
      ex_mem_q   <= 1'b0;
      ex_dst_q   <= 5'd0;
      mem_vld_q  <= 1'b0;
      mem_mem_q  <= 1'b0;
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
      stall_q    <= '0;
    end else begin
      if (idex_en) begin
        ex_vld_q <= ins_valid & ~idex_flush;
        ex_ld_q  <= is_load;
        ex_mem_q <= is_mem;
        ex_dst_q <= dst;
      end
      if (exmem_en) begin
        mem_vld_q <= ex_vld_q;
        mem_mem_q <= ex_mem_q;
      end
      case (state_q)
        RUN: begin
          wait_cnt_q <= '0;
          if (freeze) state_q <= MEM_WAIT;
        end
        MEM_WAIT: begin
          wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
          if (mem_ack || timeout_hit) state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
      if (timeout_hit) mem_err_q <= 1'b1;
      if (!pc_en && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign mem_err      = mem_err_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed-vector bench for hazard_ctrl. Inputs change 1ns
// after the rising edge; combinational outputs are checked on the falling edge.
module tb_hazard_ctrl;

  localparam logic [31:0] LW1   = 32'h5081_0000; // LW  r1,0(r4)
  localparam logic [31:0] LW0   = 32'h5080_0000; // LW  r0,0(r4)
  localparam logic [31:0] ADD   = 32'h0022_1800; // ADD r3,r1,r2
  localparam logic [31:0] ADDR0 = 32'h0002_1800; // ADD r3,r0,r2

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ins = '0;
  logic        ins_valid = 1'b0;
  logic        br_taken = 1'b0;
  logic        mem_ack = 1'b1;
  logic        pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush;
  logic        mem_req, mem_err;
  logic [15:0] stall_cycles;
  logic [5:0]  ctrl;

  int n_chk = 0;
  int n_fail = 0;

  hazard_ctrl #(.MEM_TIMEOUT(8), .CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .ins          (ins),
    .ins_valid    (ins_valid),
    .br_taken     (br_taken),
    .mem_ack      (mem_ack),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .idex_en      (idex_en),
    .exmem_en     (exmem_en),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .mem_req      (mem_req),
    .mem_err      (mem_err),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  // {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush}
  assign ctrl = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [31:0] i, input logic v,
                      input logic b, input logic a);
    @(posedge clk);
    #1;
    reset     = rst;
    ins       = i;
    ins_valid = v;
    br_taken  = b;
    mem_ack   = a;
    @(negedge clk);
    $display("t=%0t rst=%b ins=%h v=%b br=%b ack=%b ctrl=%b req=%b err=%b stall=%0d",
             $time, rst, i, v, b, a, ctrl, mem_req, mem_err, stall_cycles);
  endtask

  initial begin
    // Reset held two cycles.
    step(1'b1, '0, 1'b0, 1'b0, 1'b1);
    chk("rst_ctrl0", ctrl, 6'b000011);
    chk("rst_req0", mem_req, 1'b0);
    step(1'b1, '0, 1'b0, 1'b0, 1'b1);
    chk("rst_ctrl1", ctrl, 6'b000011);
    chk("rst_err", mem_err, 1'b0);
    chk("rst_stall", stall_cycles, 16'd0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("idle_ctrl", ctrl, 6'b111100);
    chk("idle_stall", stall_cycles, 16'd0);

    // Load-use: LW r1 then ADD reading r1.
    step(1'b0, LW1, 1'b1, 1'b0, 1'b1);
    chk("lw_ctrl", ctrl, 6'b111100);
    step(1'b0, ADD, 1'b1, 1'b0, 1'b1);
    chk("lu_ctrl", ctrl, 6'b001101);
    chk("lu_stall_pre", stall_cycles, 16'd0);
    step(1'b0, ADD, 1'b1, 1'b0, 1'b1);
    chk("lu_norepeat", ctrl, 6'b111100);
    chk("lu_stall", stall_cycles, 16'd1);
    chk("lu_memreq", mem_req, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("lu_memreq_off", mem_req, 1'b0);

    // LW with destination r0 never stalls, even vs. a reader of r0.
    step(1'b0, LW0, 1'b1, 1'b0, 1'b1);
    step(1'b0, ADDR0, 1'b1, 1'b0, 1'b1);
    chk("r0_ctrl", ctrl, 6'b111100);
    chk("r0_stall", stall_cycles, 16'd1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("r0_ack_same", ctrl, 6'b111100);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Memory freeze, ack after 3 cycles.
    step(1'b0, LW1, 1'b1, 1'b0, 1'b0);
    chk("ack3_noreq", ctrl, 6'b111100);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("ack3_ex", ctrl, 6'b111100);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("ack3_frz", ctrl, 6'b000000);
      chk("ack3_req", mem_req, 1'b1);
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("ack3_rel", ctrl, 6'b111100);
    chk("ack3_relreq", mem_req, 1'b1);
    chk("ack3_stall", stall_cycles, 16'd4);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("ack3_run", ctrl, 6'b111100);
    chk("ack3_reqoff", mem_req, 1'b0);

    // Timeout: no ack, freeze exactly 8 cycles.
    step(1'b0, LW1, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("to_frz", ctrl, 6'b000000);
      chk("to_err_pre", mem_err, 1'b0);
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("to_rel", ctrl, 6'b111100);
    chk("to_relreq", mem_req, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("to_reqoff", mem_req, 1'b0);
    chk("to_err", mem_err, 1'b1);
    chk("to_stall", stall_cycles, 16'd12);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("to_err_sticky", mem_err, 1'b1);

    // Branch taken beats load-use.
    step(1'b0, LW1, 1'b1, 1'b0, 1'b1);
    step(1'b0, ADD, 1'b1, 1'b1, 1'b1);
    chk("br_lu_ctrl", ctrl, 6'b111111);
    chk("br_lu_stall", stall_cycles, 16'd12);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("br_lu_after", ctrl, 6'b111100);
    chk("br_lu_stall2", stall_cycles, 16'd12);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Branch taken held during a memory freeze.
    step(1'b0, LW1, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("brf_pre", ctrl, 6'b111100);
    for (int k = 0; k < 2; k++) begin
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      chk("brf_frz", ctrl, 6'b000000);
    end
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    chk("brf_rel", ctrl, 6'b111111);
    chk("brf_stall", stall_cycles, 16'd14);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("brf_run", ctrl, 6'b111100);

    // Reset mid-wait.
    step(1'b0, LW1, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("rmw_frz", ctrl, 6'b000000);
    step(1'b1, '0, 1'b0, 1'b0, 1'b0);
    chk("rmw_ctrl", ctrl, 6'b000011);
    chk("rmw_req", mem_req, 1'b0);
    step(1'b1, '0, 1'b0, 1'b0, 1'b0);
    chk("rmw_err", mem_err, 1'b0);
    chk("rmw_stall", stall_cycles, 16'd0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("rmw_run", ctrl, 6'b111100);
    chk("rmw_req_off", mem_req, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. It sits beside the dependency-check/decode logic and drives the stage-register enables and flushes for IF/ID, ID/EX and EX/MEM. It inserts a one-cycle bubble on load-use hazards and flushes wrong-path instructions on a taken branch. It also freezes the whole pipeline while data memory completes an access under a req/ack handshake with timeout.

## Interface
- MEM_TIMEOUT, 8: max wait cycles for mem_ack before forced release (≥2).
- CNT_W, 16: width of stall_cycles counter.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- ins  in  32  instruction in ID (op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11]).
- ins_valid  in  1  ID holds a real instruction.
- br_taken  in  1  branch in EX resolved taken (level, from EX register).
- mem_ack  in  1  data memory completes current access.
- pc_en / ifid_en / idex_en / exmem_en  out  1 each  stage-register load enables.
- ifid_flush / idex_flush  out  1 each  load a bubble (valid=0) into that register.
- mem_req  out  1  access request for the instruction in MEM.
- mem_err  out  1  sticky: a memory timeout occurred.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0.

## Operation
- Classification (opcodes from package): RTYPE 000000 dst=rd, reads rs,rt; LW 010100 dst=rt, reads rs, is_load, is_mem; SW 010101 reads rs,rt, is_mem, no dst; BEQ 000100 reads rs,rt, no dst; ADDI 001101 dst=rt, reads rs; any other opcode: reads rs, no dst. dst=0 means no dst.
- Shadow pipeline: ex_vld/ex_dst/ex_ld/ex_mem load on idex_en (ex_vld<=ins_valid & ~idex_flush). mem_vld/mem_mem load ex_* on exmem_en.
- mem_req = mem_vld & mem_mem. freeze = mem_req & ~mem_ack & ~timeout_hit.
- load_use = ins_valid & ex_vld & ex_ld & ex_dst≠0 & ((reads_rs & rs==ex_dst) | (reads_rt & rt==ex_dst)).
- Priority, highest first:
  - freeze: all four enables 0, flushes 0.
  - br_taken: all enables 1, ifid_flush=1, idex_flush=1.
  - load_use: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1.
  - else: all enables 1, flushes 0.
- FSM states RUN, MEM_WAIT.
  - RUN→MEM_WAIT when freeze. MEM_WAIT→RUN on mem_ack or timeout_hit.
  - wait_cnt clears in RUN and increments in MEM_WAIT.
  - timeout_hit = MEM_WAIT & wait_cnt==MEM_TIMEOUT-1.
  - timeout_hit releases the freeze as a forced ack and sets mem_err (sticky until reset).
- br_taken is ignored while frozen. The EX register is held, so the flush is applied in the release cycle.
- stall_cycles increments every cycle pc_en=0 and holds at all-ones.

## Timing
- While reset=1: enables 0, ifid_flush=idex_flush=1, mem_req=0.
- On reset: state RUN, all shadow valids 0, wait_cnt 0, mem_err 0, stall_cycles 0. Normal run begins on the first cycle after reset falls.
- Control outputs are combinational from ins/br_taken/mem_ack and registered state: zero-cycle latency.
- Load-use costs exactly 1 cycle. The next cycle has a bubble in EX, so there is no repeat stall.
- mem_ack in the same cycle as mem_req: no stall.
- Ack after k cycles: freeze for k cycles. With no ack, freeze lasts exactly MEM_TIMEOUT cycles.
- mem_ack without mem_req is ignored.
- Reset mid-wait: immediate return to RUN with mem_req=0.

## Structure
- mips_pkg holds:
  - opcode localparams OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI;
  - field-slice constants;
  - state enum typedef {RUN, MEM_WAIT}.
- Sub-module hazard_decode: combinational classifier, ins → reads_rs, reads_rt, dst[4:0], is_load, is_mem.
- hazard_ctrl holds the shadow registers, FSM, timeout counter, stall counter and priority logic.

## Test plan
- Reset held 2 cycles: all enables 0, both flushes 1, mem_err 0, stall_cycles 0. After release with ins_valid=0: all enables 1.
- LW r1,0(r4) (0x50810000) in EX, then ADD r3,r1,r2 (0x00221800) in ID: one cycle pc_en=0, idex_flush=1, stall_cycles=1.
  - Same sequence with LW dst r0: no stall.
- LW reaches MEM, mem_ack raised 3 cycles later: mem_req=1 throughout; 3 cycles all enables 0; stall_cycles +3; state back to RUN.
- MEM_TIMEOUT=8, no mem_ack: freeze exactly 8 cycles, then release. mem_err=1 stays set until reset.
- br_taken=1 in the same cycle as load_use: pc_en=1, ifid_flush=idex_flush=1, stall_cycles unchanged.
- br_taken held during a memory freeze: no flush while frozen. ifid_flush/idex_flush=1 in the mem_ack cycle.
